leiwand_rv32_bus_master: RTL

- Initiator side of the leiwand_rv32 memory bus. Drives the cyc/stb/we/addr/dat/dat_wr_size request lines that the RAM and peripheral slaves respond to.
- Accepts one load/store at a time from the core LSU and runs a single bus transaction for it.
- Aligns and sign- or zero-extends read data, rejects misaligned accesses, and times out unresponsive slaves.

---
 rtl/leiwand_rv32_bus_master_if.sv | 39 +++
 rtl/leiwand_rv32_bus_master.sv | 119 +++++++++++
 2 files changed

// File: rtl/leiwand_rv32_bus_master_if.sv
// Core-side request/response lines and bus request/response lines of the leiwand_rv32 bus master.
// The master modport is the bus master's view; the slave modport is the view of the core and bus peers.
interface leiwand_rv32_bus_master_if #(
   parameter int MEM_WIDTH = 32
);
   logic                 i_req;
   logic [MEM_WIDTH-1:0] i_addr;
   logic [MEM_WIDTH-1:0] i_dat;
   logic                 i_we;
   logic [2:0]           i_size;
   logic                 i_unsigned;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;
   logic [MEM_WIDTH-1:0] o_rdat;
   logic                 o_wb_cyc;
   logic                 o_wb_stb;
   logic                 o_wb_we;
   logic [MEM_WIDTH-1:0] o_wb_addr;
   logic [MEM_WIDTH-1:0] o_wb_dat;
   logic [2:0]           o_wb_dat_wr_size;
   logic [MEM_WIDTH-1:0] i_wb_dat;
   logic                 i_wb_ack;
   logic                 i_wb_stall;

   modport master (
      input  i_req, i_addr, i_dat, i_we, i_size, i_unsigned,
      input  i_wb_dat, i_wb_ack, i_wb_stall,
      output o_busy, o_done, o_err, o_rdat,
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat, o_wb_dat_wr_size
   );

   modport slave (
      output i_req, i_addr, i_dat, i_we, i_size, i_unsigned,
      output i_wb_dat, i_wb_ack, i_wb_stall,
      input  o_busy, o_done, o_err, o_rdat,
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat, o_wb_dat_wr_size
   );
endinterface

// File: rtl/leiwand_rv32_bus_master.sv
// Single-outstanding load/store bus master: req -> stb next cycle, done one cycle after ack (4 cycles uncontended).
// Backpressure: stall parks the request in ARB; ARB and WAIT each abort with err after TIMEOUT cycles.
module leiwand_rv32_bus_master #(
   parameter int MEM_WIDTH = 32,
   parameter int TIMEOUT   = 16
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   leiwand_rv32_bus_master_if.master       bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ARB, REQ, WAIT} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic                 uns;
   logic                 legal, capture, done_nxt, err_nxt;
   logic [7:0]           byte_sel;
   logic [15:0]          half_sel;
   logic [MEM_WIDTH-1:0] load_val;

   always_comb begin
      legal = (bus.i_size == 3'd1)
           || (bus.i_size == 3'd2 && !bus.i_addr[0])
           || (bus.i_size == 3'd4 && bus.i_addr[1:0] == 2'b00);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      capture   = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (bus.i_req) begin
               capture = 1'b1;
               if (!legal)
                  err_nxt = 1'b1;
               else if (bus.i_wb_stall)
                  state_nxt = ARB;
               else
                  state_nxt = REQ;
            end
         end
         ARB: begin
            if (!bus.i_wb_stall) begin
               state_nxt = REQ;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         REQ: begin
            // stall is deliberately not looked at here: slaves raise it in response to stb
            cnt_nxt   = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.i_wb_ack) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Lane selection uses the captured address/size, which stay stable through WAIT.
   always_comb begin
      byte_sel = 8'(bus.i_wb_dat >> {bus.o_wb_addr[1:0], 3'b000});
      half_sel = 16'(bus.i_wb_dat >> {bus.o_wb_addr[1], 4'b0000});
      case (bus.o_wb_dat_wr_size)
         3'd1:    load_val = {{(MEM_WIDTH-8){byte_sel[7] & ~uns}}, byte_sel};
         3'd2:    load_val = {{(MEM_WIDTH-16){half_sel[15] & ~uns}}, half_sel};
         default: load_val = bus.i_wb_dat;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state                <= IDLE;
         cnt                  <= '0;
         uns                  <= 1'b0;
         bus.o_busy           <= 1'b0;
         bus.o_done           <= 1'b0;
         bus.o_err            <= 1'b0;
         bus.o_rdat           <= '0;
         bus.o_wb_cyc         <= 1'b0;
         bus.o_wb_stb         <= 1'b0;
         bus.o_wb_we          <= 1'b0;
         bus.o_wb_addr        <= '0;
         bus.o_wb_dat         <= '0;
         bus.o_wb_dat_wr_size <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (capture) begin
            bus.o_wb_addr        <= bus.i_addr;
            bus.o_wb_dat         <= bus.i_dat;
            bus.o_wb_we          <= bus.i_we;
            bus.o_wb_dat_wr_size <= bus.i_size;
            uns                  <= bus.i_unsigned;
         end
         bus.o_wb_cyc <= (state_nxt == REQ) || (state_nxt == WAIT);
         bus.o_wb_stb <= (state_nxt == REQ);
         bus.o_busy   <= (state_nxt != IDLE);
         bus.o_done   <= done_nxt;
         bus.o_err    <= err_nxt;
         if (done_nxt && !bus.o_wb_we)
            bus.o_rdat <= load_val;
      end
   end
endmodule
